platform_collision_arbiter: RTL and testbench

PLATFORM_COLLISION_ARBITER -- requirements
Module: platform_collision_arbiter

---
 rtl/platform_collision_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_platform_collision_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_collision_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : platform_collision_arbiter (with game_pkg platform table)
//  Description : Round-robin arbiter for two requesters (Tom, Jerry) that
//                scans six platforms, one per cycle, and reports a 2-bit
//                collision code for the granted requester's bounding box.
//  Revision    : 1.0 - initial release
// ============================================================================

package game_pkg;
    localparam logic [9:0] P1_X_START   = 10'd100;
    localparam logic [9:0] P1_Y_COLLISION = 10'd400;
    localparam logic [9:0] P1_LENGTH    = 10'd120;
    localparam logic [9:0] P2_X_START   = 10'd40;
    localparam logic [9:0] P2_Y_COLLISION = 10'd360;
    localparam logic [9:0] P2_LENGTH    = 10'd100;
    localparam logic [9:0] P3_X_START   = 10'd480;
    localparam logic [9:0] P3_Y_COLLISION = 10'd260;
    localparam logic [9:0] P3_LENGTH    = 10'd120;
    localparam logic [9:0] P4_X_START   = 10'd76;
    localparam logic [9:0] P4_Y_COLLISION = 10'd200;
    localparam logic [9:0] P4_LENGTH    = 10'd80;
    localparam logic [9:0] P5_X_START   = 10'd350;
    localparam logic [9:0] P5_Y_COLLISION = 10'd140;
    localparam logic [9:0] P5_LENGTH    = 10'd100;
    localparam logic [9:0] P6_X_START   = 10'd520;
    localparam logic [9:0] P6_Y_COLLISION = 10'd80;
    localparam logic [9:0] P6_LENGTH    = 10'd90;
endpackage

module platform_collision_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_PLAT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [9:0]         x0_i,
    input  logic [9:0]         y0_i,
    input  logic [9:0]         x1_i,
    input  logic [9:0]         y1_i,
    input  logic [9:0]         w0_i,
    input  logic [9:0]         h0_i,
    input  logic [9:0]         w1_i,
    input  logic [9:0]         h1_i,
    output logic [NUM_REQ-1:0] done_o,
    output logic [1:0]         result_o,
    output logic               gnt_id_o,
    output logic               busy_o
);
    import game_pkg::*;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [2:0] c_LAST_IDX = 3'(NUM_PLAT - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [1:0]         acc_q, acc_d;
    logic [9:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]         result_q, result_d;
    logic               gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;

    logic [9:0]  w_px, w_py, w_pl;
    logic [10:0] w_x, w_y, w_xr, w_yb, w_pxe, w_pye, w_pr;
    logic        w_side, w_land, w_below;
    logic [1:0]  w_code;
    logic        w_grant;

    // Platform table lookup for the platform currently being scanned.
    always_comb begin
        w_px = P1_X_START;
        w_py = P1_Y_COLLISION;
        w_pl = P1_LENGTH;
        case (idx_q)
            3'd1: begin w_px = P2_X_START; w_py = P2_Y_COLLISION; w_pl = P2_LENGTH; end
            3'd2: begin w_px = P3_X_START; w_py = P3_Y_COLLISION; w_pl = P3_LENGTH; end
            3'd3: begin w_px = P4_X_START; w_py = P4_Y_COLLISION; w_pl = P4_LENGTH; end
            3'd4: begin w_px = P5_X_START; w_py = P5_Y_COLLISION; w_pl = P5_LENGTH; end
            3'd5: begin w_px = P6_X_START; w_py = P6_Y_COLLISION; w_pl = P6_LENGTH; end
            default: ;
        endcase
    end

    // Edge sums are widened to 11 bits so x+w near the screen edge never wraps.
    assign w_x   = {1'b0, x_q};
    assign w_y   = {1'b0, y_q};
    assign w_xr  = {1'b0, x_q} + {1'b0, w_q};
    assign w_yb  = {1'b0, y_q} + {1'b0, h_q};
    assign w_pxe = {1'b0, w_px};
    assign w_pye = {1'b0, w_py};
    assign w_pr  = {1'b0, w_px} + {1'b0, w_pl};

    // Per-platform collision code, side contact taking priority over top/bottom.
    always_comb begin
        w_side  = ((w_x == w_pr) || (w_xr == w_pxe)) && (w_yb >= w_pye) && (w_y <= w_pye);
        w_land  = (w_yb == w_pye) && (w_xr >= w_pxe) && (w_x <= w_pr);
        w_below = (w_y == w_pye) && (w_xr >= w_pxe) && (w_x <= w_pr);
        if (w_side) begin
            w_code = 2'b11;
        end else if (w_land) begin
            w_code = 2'b10;
        end else if (w_below) begin
            w_code = 2'b01;
        end else begin
            w_code = 2'b00;
        end
    end

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant = (req_i[0] && req_i[1]) ? ~last_q : req_i[1];

    // Next-state and output computation for the IDLE/SCAN machine.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        done_d   = '0;
        result_d = result_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = w_grant;
                    last_d  = w_grant;
                    x_d     = w_grant ? x1_i : x0_i;
                    y_d     = w_grant ? y1_i : y0_i;
                    w_d     = w_grant ? w1_i : w0_i;
                    h_d     = w_grant ? h1_i : h0_i;
                    acc_d   = 2'b00;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q | w_code;
                idx_d = idx_q + 3'd1;
                if (idx_q == c_LAST_IDX) begin
                    result_d      = acc_q | w_code;
                    done_d[gnt_q] = 1'b1;
                    busy_d        = 1'b0;
                    idx_d         = 3'd0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any scan in progress without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            acc_q    <= 2'b00;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            w_q      <= 10'd0;
            h_q      <= 10'd0;
            done_q   <= '0;
            result_q <= 2'b00;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            done_q   <= done_d;
            result_q <= result_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;
    assign gnt_id_o = gnt_q;
    assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_platform_collision_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_platform_collision_arbiter
//  Description : Self-checking bench: directed vector table, reset and tie
//                sequences, and randomized transactions against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_platform_collision_arbiter;
    import game_pkg::*;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [9:0] h;
    } box_t;

    typedef struct {
        string      name;
        logic [1:0] req;
        box_t       b0;
        box_t       b1;
        int         g;
        int         res;
    } vec_t;

    localparam int PXA [6] = '{int'(P1_X_START), int'(P2_X_START), int'(P3_X_START),
                               int'(P4_X_START), int'(P5_X_START), int'(P6_X_START)};
    localparam int PYA [6] = '{int'(P1_Y_COLLISION), int'(P2_Y_COLLISION), int'(P3_Y_COLLISION),
                               int'(P4_Y_COLLISION), int'(P5_Y_COLLISION), int'(P6_Y_COLLISION)};
    localparam int PLA [6] = '{int'(P1_LENGTH), int'(P2_LENGTH), int'(P3_LENGTH),
                               int'(P4_LENGTH), int'(P5_LENGTH), int'(P6_LENGTH)};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [9:0] x0_i = '0, y0_i = '0, x1_i = '0, y1_i = '0;
    logic [9:0] w0_i = '0, h0_i = '0, w1_i = '0, h1_i = '0;
    logic [1:0] done_o;
    logic [1:0] result_o;
    logic       gnt_id_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    platform_collision_arbiter #(.NUM_REQ(2), .NUM_PLAT(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .x0_i     (x0_i),
        .y0_i     (y0_i),
        .x1_i     (x1_i),
        .y1_i     (y1_i),
        .w0_i     (w0_i),
        .h0_i     (h0_i),
        .w1_i     (w1_i),
        .h1_i     (h1_i),
        .done_o   (done_o),
        .result_o (result_o),
        .gnt_id_o (gnt_id_o),
        .busy_o   (busy_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic box_t mk_box(input int x, input int y, input int w, input int h);
        box_t b;
        b.x = 10'(x);
        b.y = 10'(y);
        b.w = 10'(w);
        b.h = 10'(h);
        return b;
    endfunction

    // Reference: OR of per-platform codes, evaluated with unbounded integers.
    function automatic int ref_code(input box_t b);
        int code;
        int x, y, w, h;
        code = 0;
        x = int'(b.x); y = int'(b.y); w = int'(b.w); h = int'(b.h);
        for (int p = 0; p < 6; p++) begin
            if ((x == PXA[p] + PLA[p] || x + w == PXA[p]) && y + h >= PYA[p] && y <= PYA[p])
                code = code | 3;
            else if (y + h == PYA[p] && x + w >= PXA[p] && x <= PXA[p] + PLA[p])
                code = code | 2;
            else if (y == PYA[p] && x + w >= PXA[p] && x <= PXA[p] + PLA[p])
                code = code | 1;
        end
        return code;
    endfunction

    function automatic box_t rand_box();
        int p, m, x, y, w, h;
        p = int'($urandom_range(0, 5));
        m = int'($urandom_range(0, 3));
        w = int'($urandom_range(1, 40));
        h = int'($urandom_range(1, 40));
        case (m)
            0: begin x = PXA[p] - w + int'($urandom_range(0, PLA[p] + w)); y = PYA[p] - h; end
            1: begin x = PXA[p] - w + int'($urandom_range(0, PLA[p] + w)); y = PYA[p]; end
            2: begin
                x = ($urandom_range(0, 1) == 1) ? PXA[p] - w : PXA[p] + PLA[p];
                y = PYA[p] - h + int'($urandom_range(0, h));
            end
            default: begin
                x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
                w = int'($urandom_range(0, 1023)); h = int'($urandom_range(0, 1023));
            end
        endcase
        return mk_box(x, y, w, h);
    endfunction

    task automatic set_boxes(input box_t b0, input box_t b1);
        x0_i = b0.x; y0_i = b0.y; w0_i = b0.w; h0_i = b0.h;
        x1_i = b1.x; y1_i = b1.y; w1_i = b1.w; h1_i = b1.h;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction from IDLE: request for one cycle, then scramble inputs.
    task automatic run_txn(input logic [1:0] req, input box_t b0, input box_t b1,
                           output int lat, output int dn, output int dn2,
                           output int res, output int g, output int bcnt);
        lat = -1; dn = 0; dn2 = 0; res = 0; g = 0; bcnt = 0;
        @(negedge clk);
        set_boxes(b0, b1);
        req_i = req;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_i = 2'b00;
                set_boxes(rand_box(), rand_box());
            end
            if (busy_o) bcnt++;
            if (done_o != 2'b00) begin
                lat = n - 1;
                dn  = int'(done_o);
                res = int'(result_o);
                g   = int'(gnt_id_o);
                @(negedge clk);
                dn2 = int'(done_o);
                break;
            end
        end
    endtask

    vec_t vecs [6];

    initial begin
        int lat, dn, dn2, res, g, bcnt, last, eg, er, n_done, dcount;
        int t_d [4];
        int g_d [4];
        int r_d [4];
        int v_d [4];
        int cyc;
        logic [1:0] rq;
        box_t b0, b1, nohit, land, below;

        nohit = mk_box(1, 1, 16, 16);
        land  = mk_box(int'(P3_X_START) + 4, int'(P3_Y_COLLISION) - 20, 16, 20);
        below = mk_box(int'(P5_X_START) + 10, int'(P5_Y_COLLISION), 10, 10);

        vecs[0] = '{"no_hit",   2'b01, nohit, land, 0, 0};
        vecs[1] = '{"landing",  2'b10, nohit, land, 1, 2};
        vecs[2] = '{"side_below", 2'b01,
                    mk_box(int'(P1_X_START) - 20, int'(P2_Y_COLLISION), 20, 50), nohit, 0, 3};
        vecs[3] = '{"wrap",     2'b01,
                    mk_box(1000, int'(P4_Y_COLLISION) - 10, 100, 20), land, 0, 0};
        vecs[4] = '{"below",    2'b10, nohit, below, 1, 1};
        vecs[5] = '{"corner",   2'b10, nohit,
                    mk_box(int'(P6_X_START) - 10, int'(P6_Y_COLLISION) - 20, 10, 20), 1, 3};

        // Reset state
        @(negedge clk);
        chk("rst_done", int'(done_o), 0);
        chk("rst_result", int'(result_o), 0);
        chk("rst_gnt", int'(gnt_id_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            run_txn(vecs[i].req, vecs[i].b0, vecs[i].b1, lat, dn, dn2, res, g, bcnt);
            chk({vecs[i].name, "_latency"}, lat, 6);
            chk({vecs[i].name, "_done"}, dn, 1 << vecs[i].g);
            chk({vecs[i].name, "_done_width"}, dn2, 0);
            chk({vecs[i].name, "_busy_cycles"}, bcnt, 6);
            chk({vecs[i].name, "_result"}, res, vecs[i].res);
            chk({vecs[i].name, "_gnt"}, g, vecs[i].g);
        end

        // Reset in the middle of a scan
        @(negedge clk);
        set_boxes(below, nohit);
        req_i = 2'b01;
        @(negedge clk);
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_result", int'(result_o), 0);
        chk("mid_rst_gnt", int'(gnt_id_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done_o != 2'b00) dcount++;
        end
        chk("mid_no_done", dcount, 0);
        run_txn(2'b01, below, nohit, lat, dn, dn2, res, g, bcnt);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_result", res, 1);
        chk("post_rst_gnt", g, 0);

        // Tie held for four transactions right after reset
        reset_pulse();
        @(negedge clk);
        set_boxes(nohit, land);
        req_i = 2'b11;
        n_done = 0;
        cyc = 0;
        for (int n = 0; n < 60 && n_done < 4; n++) begin
            @(negedge clk);
            cyc++;
            if (done_o != 2'b00) begin
                t_d[n_done] = cyc;
                g_d[n_done] = int'(gnt_id_o);
                r_d[n_done] = int'(result_o);
                v_d[n_done] = int'(done_o);
                n_done++;
            end
        end
        req_i = 2'b00;
        chk("tie_count", n_done, 4);
        for (int i = 0; i < n_done; i++) begin
            chk($sformatf("tie_gnt_%0d", i), g_d[i], i % 2);
            chk($sformatf("tie_done_%0d", i), v_d[i], 1 << (i % 2));
            chk($sformatf("tie_result_%0d", i), r_d[i], ref_code((i % 2 == 1) ? land : nohit));
            if (i > 0) chk($sformatf("tie_spacing_%0d", i), t_d[i] - t_d[i-1], 7);
        end

        // Randomized transactions against the reference model
        reset_pulse();
        last = 1;
        for (int t = 0; t < 40; t++) begin
            rq = 2'($urandom_range(1, 3));
            b0 = rand_box();
            b1 = rand_box();
            if (rq == 2'b01) eg = 0;
            else if (rq == 2'b10) eg = 1;
            else eg = 1 - last;
            last = eg;
            er = ref_code((eg == 1) ? b1 : b0);
            run_txn(rq, b0, b1, lat, dn, dn2, res, g, bcnt);
            chk($sformatf("rand%0d_gnt", t), g, eg);
            chk($sformatf("rand%0d_result", t), res, er);
            chk($sformatf("rand%0d_latency", t), lat, 6);
            chk($sformatf("rand%0d_done", t), dn, 1 << eg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
